axi_wr_arbiter: RTL and testbench
=================================

AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 2: maximum AW bursts accepted by the slave whose B response is still pending (legal range 1..7).
REQ-002 Parameter AXI_SIZE, default 3'b010: constant AWSIZE (4-byte beats).
REQ-003 Port ACLK  in  1  sole clock; all logic on rising edge.
REQ-004 Port ARESETn  in  1  reset, asynchronous, active-low.
REQ-005 Port REQ_VALID  in  2  per-requester burst request (bit i = requester i).
REQ-006 Port REQ_READY  out  2  one-cycle grant/accept pulse per requester.
REQ-007 Port REQ_ADDR  in  64  start address; [32i+31:32i] for requester i.
REQ-008 Port REQ_LEN  in  16  AXI LEN (beats-1); [8i+7:8i] for requester i.
REQ-009 Port REQ_WDATA  in  64  write beat data; [32i+31:32i] for requester i.
REQ-010 Port REQ_WVALID / REQ_WREADY  in / out  2 / 2  per-requester data handshake.
REQ-011 Port DONE_VALID / DONE_RESP  out / out  2 / 4  per-requester completion pulse and BRESP ([2i+1:2i]).
REQ-012 Ports M_AXI_AWADDR 32, M_AXI_AWID 4, M_AXI_AWLEN 8, M_AXI_AWSIZE 3, M_AXI_AWBURST 2, M_AXI_AWVALID 1 out; M_AXI_AWREADY 1 in.
REQ-013 Ports M_AXI_WDATA 32, M_AXI_WSTRB 4, M_AXI_WLAST 1, M_AXI_WVALID 1 out; M_AXI_WREADY 1 in.
REQ-014 Ports M_AXI_BID 4, M_AXI_BRESP 2, M_AXI_BVALID 1 in; M_AXI_BREADY 1 out.

Function
REQ-015 FSM states IDLE, BURST; IDLE->BURST on grant; BURST->IDLE in the cycle where both AW handshake and last-W handshake have completed (either order, or same cycle).
REQ-016 Grant in IDLE only when any REQ_VALID=1 and outstanding count < MAX_OUTSTANDING; otherwise remain IDLE, REQ_READY=0.
REQ-017 Round-robin: both valid -> grant the requester not granted last; after reset requester 0 has priority.
REQ-018 On grant: REQ_READY[g]=1 for that one cycle; register AWADDR, AWLEN from requester g; AWID={3'b0,g}; AWBURST=2'b01 (INCR); AWSIZE=AXI_SIZE; AWVALID=1 from next cycle.
REQ-019 AWVALID held with stable payload until AWREADY sampled high, then deasserted next cycle.
REQ-020 W streaming in BURST concurrently with AW: M_AXI_WVALID=REQ_WVALID[g]; REQ_WREADY[g]=M_AXI_WREADY; WDATA=REQ_WDATA slice g; WSTRB=4'hF; non-granted REQ_WREADY=0.
REQ-021 8-bit beat counter cleared at grant, incremented per W handshake; WLAST=1 when counter==AWLEN (AWLEN=0 -> WLAST on first beat).
REQ-022 Outstanding counter (3 bits): +1 on AW handshake, -1 on B handshake, unchanged when both occur in same cycle; never exceeds MAX_OUTSTANDING.
REQ-023 M_AXI_BREADY constantly 1 out of reset.
REQ-024 On B handshake: DONE_VALID[BID[0]]=1 for one cycle next cycle, DONE_RESP slice = BRESP; other requester's DONE_VALID=0.
REQ-025 B arriving while a new grant or burst is in progress shall be accepted without stalling AW/W.
REQ-026 BRESP other than OKAY shall be forwarded unchanged; arbiter behaviour unaffected.

Reset
REQ-027 ARESETn low asynchronously forces: state IDLE, AWVALID=0, WVALID path disabled (REQ_WREADY=0), WLAST=0, REQ_READY=0, DONE_VALID=0, outstanding=0, beat counter=0, RR priority=requester 0, AWADDR/AWLEN/AWID=0, AWBURST=2'b01, AWSIZE=AXI_SIZE, BREADY=1.
REQ-028 Reset mid-burst abandons the burst; no DONE pulse is generated for it after release.
REQ-029 First grant possible no earlier than the second rising edge after ARESETn deasserts.

Verification
REQ-030 Single: req0 addr 0x100, len 3, slave always ready -> AW 0x100/ID0/LEN3, 4 beats, WLAST on beat 4, B OKAY -> DONE_VALID[0] one pulse, DONE_RESP=00.
REQ-031 Contention: both valid continuously, len 0 -> grants alternate 0,1,0,1; AWID matches; no grant while outstanding==2.
REQ-032 Backpressure: AWREADY low 5 cycles, WREADY toggling -> AW payload stable, WDATA beats in order, exactly LEN+1 W handshakes.
REQ-033 W-before-AW: all 4 beats accepted before AWREADY rises -> FSM returns IDLE only after AW handshake.
REQ-034 Simultaneous AW handshake and B handshake with outstanding=1 -> count stays 1; BID=1 with BRESP=10 -> DONE_VALID[1], DONE_RESP[3:2]=10.
REQ-035 Reset asserted during beat 2 of 4 -> all outputs at REQ-027 values immediately; after release, new req0 len 1 completes normally.

Source files
------------

// File: rtl/axi_wr_arbiter_if.sv
// Requester-side and AXI4 write-master signal bundle for axi_wr_arbiter.
// master = arbiter view, slave = requesters plus AXI slave (bench) view.
interface axi_wr_arbiter_if;
    logic [1:0]  REQ_VALID;
    logic [1:0]  REQ_READY;
    logic [63:0] REQ_ADDR;
    logic [15:0] REQ_LEN;
    logic [63:0] REQ_WDATA;
    logic [1:0]  REQ_WVALID;
    logic [1:0]  REQ_WREADY;
    logic [1:0]  DONE_VALID;
    logic [3:0]  DONE_RESP;

    logic [31:0] M_AXI_AWADDR;
    logic [3:0]  M_AXI_AWID;
    logic [7:0]  M_AXI_AWLEN;
    logic [2:0]  M_AXI_AWSIZE;
    logic [1:0]  M_AXI_AWBURST;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;

    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WLAST;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;

    logic [3:0]  M_AXI_BID;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID;
    logic        M_AXI_BREADY;

    modport master (
        input  REQ_VALID, REQ_ADDR, REQ_LEN, REQ_WDATA, REQ_WVALID,
        output REQ_READY, REQ_WREADY, DONE_VALID, DONE_RESP,
        output M_AXI_AWADDR, M_AXI_AWID, M_AXI_AWLEN, M_AXI_AWSIZE,
        output M_AXI_AWBURST, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BID, M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY
    );

    modport slave (
        output REQ_VALID, REQ_ADDR, REQ_LEN, REQ_WDATA, REQ_WVALID,
        input  REQ_READY, REQ_WREADY, DONE_VALID, DONE_RESP,
        input  M_AXI_AWADDR, M_AXI_AWID, M_AXI_AWLEN, M_AXI_AWSIZE,
        input  M_AXI_AWBURST, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BID, M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY
    );
endinterface

// File: rtl/axi_wr_arbiter.sv
// Two-requester AXI4 write arbiter: round-robin grant, one AW/W burst at a time,
// B responses routed back by BID[0] while an outstanding count throttles grants.
module axi_wr_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [2:0]  AXI_SIZE        = 3'b010
) (
    input logic              ACLK,
    input logic              ARESETn,
    axi_wr_arbiter_if.master bus
);
    typedef enum logic {IDLE, BURST} state_e;

    localparam logic [2:0] MAX_OS = 3'(MAX_OUTSTANDING);

    state_e      state_q, state_d;
    logic        init_q, init_d;
    logic        prio_q, prio_d;
    logic        gnt_q, gnt_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [7:0]  awlen_q, awlen_d;
    logic        awvalid_q, awvalid_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [7:0]  beat_q, beat_d;
    logic [2:0]  os_q, os_d;
    logic [1:0]  done_valid_q, done_valid_d;
    logic [3:0]  done_resp_q, done_resp_d;

    logic grant, gsel, aw_hs, w_hs, b_hs, w_open, wlast, wvalid;
    logic unused_bid;

    assign unused_bid = ^bus.M_AXI_BID[3:1];

    // init_q holds off the first grant until one edge after reset release
    assign grant = (state_q == IDLE) && init_q && (os_q < MAX_OS)
                   && (|bus.REQ_VALID);
    assign gsel  = (&bus.REQ_VALID) ? prio_q : bus.REQ_VALID[1];

    assign w_open = (state_q == BURST) && !w_done_q;
    assign wvalid = w_open && bus.REQ_WVALID[gnt_q];
    assign wlast  = w_open && (beat_q == awlen_q);
    assign aw_hs  = awvalid_q && bus.M_AXI_AWREADY;
    assign w_hs   = wvalid && bus.M_AXI_WREADY;
    assign b_hs   = bus.M_AXI_BVALID;

    assign bus.REQ_READY  = grant ? (2'b01 << gsel) : 2'b00;
    assign bus.REQ_WREADY = w_open ? ({1'b0, bus.M_AXI_WREADY} << gnt_q)
                                   : 2'b00;
    assign bus.DONE_VALID = done_valid_q;
    assign bus.DONE_RESP  = done_resp_q;

    assign bus.M_AXI_AWADDR  = awaddr_q;
    assign bus.M_AXI_AWID    = {3'b000, gnt_q};
    assign bus.M_AXI_AWLEN   = awlen_q;
    assign bus.M_AXI_AWSIZE  = AXI_SIZE;
    assign bus.M_AXI_AWBURST = 2'b01;
    assign bus.M_AXI_AWVALID = awvalid_q;
    assign bus.M_AXI_WDATA   = gnt_q ? bus.REQ_WDATA[63:32]
                                     : bus.REQ_WDATA[31:0];
    assign bus.M_AXI_WSTRB   = 4'hF;
    assign bus.M_AXI_WLAST   = wlast;
    assign bus.M_AXI_WVALID  = wvalid;
    assign bus.M_AXI_BREADY  = 1'b1;

    always_comb begin
        state_d   = state_q;
        init_d    = 1'b1;
        prio_d    = prio_q;
        gnt_d     = gnt_q;
        awaddr_d  = awaddr_q;
        awlen_d   = awlen_q;
        awvalid_d = awvalid_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        beat_d    = beat_q;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d   = BURST;
                    gnt_d     = gsel;
                    prio_d    = ~gsel;
                    awaddr_d  = gsel ? bus.REQ_ADDR[63:32]
                                     : bus.REQ_ADDR[31:0];
                    awlen_d   = gsel ? bus.REQ_LEN[15:8]
                                     : bus.REQ_LEN[7:0];
                    awvalid_d = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    beat_d    = 8'd0;
                end
            end
            BURST: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    beat_d = beat_q + 8'd1;
                    if (wlast) w_done_d = 1'b1;
                end
                // AW and last W may complete in either order or together
                if ((aw_done_q || aw_hs) && (w_done_q || (w_hs && wlast)))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        os_d = os_q;
        unique case ({aw_hs, b_hs})
            2'b10:   os_d = os_q + 3'd1;
            2'b01:   os_d = (os_q != 3'd0) ? os_q - 3'd1 : os_q;
            default: os_d = os_q;
        endcase
        done_valid_d = b_hs ? (2'b01 << bus.M_AXI_BID[0]) : 2'b00;
        done_resp_d  = done_resp_q;
        if (b_hs) begin
            if (bus.M_AXI_BID[0]) done_resp_d[3:2] = bus.M_AXI_BRESP;
            else                  done_resp_d[1:0] = bus.M_AXI_BRESP;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q      <= IDLE;
            init_q       <= 1'b0;
            prio_q       <= 1'b0;
            gnt_q        <= 1'b0;
            awaddr_q     <= 32'd0;
            awlen_q      <= 8'd0;
            awvalid_q    <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            beat_q       <= 8'd0;
            os_q         <= 3'd0;
            done_valid_q <= 2'b00;
            done_resp_q  <= 4'd0;
        end else begin
            state_q      <= state_d;
            init_q       <= init_d;
            prio_q       <= prio_d;
            gnt_q        <= gnt_d;
            awaddr_q     <= awaddr_d;
            awlen_q      <= awlen_d;
            awvalid_q    <= awvalid_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            beat_q       <= beat_d;
            os_q         <= os_d;
            done_valid_q <= done_valid_d;
            done_resp_q  <= done_resp_d;
        end
    end
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Bench for axi_wr_arbiter: bench-side requesters and AXI slave, checked
// each cycle against a transaction-level arbitration model.
module tb_axi_wr_arbiter;
    localparam int MAXO = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [31:0] seed;
    } burst_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [1:0]  resp;
        logic [31:0] due;
    } bent_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total, bad;

    axi_wr_arbiter_if bus ();

    axi_wr_arbiter #(.MAX_OUTSTANDING(MAXO), .AXI_SIZE(3'b010)) dut (
        .ACLK(clk),
        .ARESETn(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // requesters
    burst_t rq0[$], rq1[$];
    burst_t cur[2];
    bit     streaming[2];
    int     sbeat[2];
    int     wv_pct;
    logic [1:0] rdy_seen, whs_seen;

    // slave
    bent_t bq[$];
    int    awr_hold, wr_mode, b_delay, resp_mode;
    bit    awr_rand, b_rand, b_sync, wr_tog;

    // reference model
    bit     burst_open, aw_seen;
    int     bo_req, wcnt, last_g, outstanding, edges, cycno;
    burst_t bo;
    logic [1:0] exp_done, exp_resp;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bdata(burst_t b, int k);
        return b.seed + 32'(k) * 32'h9E3779B9;
    endfunction

    function automatic burst_t mkb(logic [31:0] a, logic [7:0] l);
        burst_t b;
        b.addr = a;
        b.len  = l;
        b.seed = $urandom;
        return b;
    endfunction

    function automatic bit idle();
        return rq0.size() == 0 && rq1.size() == 0 && !streaming[0]
            && !streaming[1] && !burst_open && bq.size() == 0
            && exp_done == 2'b00 && !bus.M_AXI_BVALID && outstanding == 0;
    endfunction

    task automatic zero_inputs();
        bus.REQ_VALID     = 2'b00;
        bus.REQ_ADDR      = 64'd0;
        bus.REQ_LEN       = 16'd0;
        bus.REQ_WDATA     = 64'd0;
        bus.REQ_WVALID    = 2'b00;
        bus.M_AXI_AWREADY = 1'b0;
        bus.M_AXI_WREADY  = 1'b0;
        bus.M_AXI_BID     = 4'd0;
        bus.M_AXI_BRESP   = 2'd0;
        bus.M_AXI_BVALID  = 1'b0;
    endtask

    task automatic reset_model();
        rq0.delete();
        rq1.delete();
        bq.delete();
        streaming[0] = 0;
        streaming[1] = 0;
        sbeat[0] = 0;
        sbeat[1] = 0;
        burst_open = 0;
        aw_seen = 0;
        wcnt = 0;
        last_g = 1;
        outstanding = 0;
        exp_done = 2'b00;
        exp_resp = 2'b00;
        rdy_seen = 2'b00;
        whs_seen = 2'b00;
        awr_hold = 0;
        awr_rand = 0;
        wr_mode = 0;
        wv_pct = 100;
        b_delay = 2;
        b_rand = 0;
        b_sync = 0;
        resp_mode = 0;
        wr_tog = 0;
    endtask

    task automatic chk_rst();
        chk("rst_req_ready", bus.REQ_READY, 0);
        chk("rst_req_wready", bus.REQ_WREADY, 0);
        chk("rst_awvalid", bus.M_AXI_AWVALID, 0);
        chk("rst_wvalid", bus.M_AXI_WVALID, 0);
        chk("rst_wlast", bus.M_AXI_WLAST, 0);
        chk("rst_done_valid", bus.DONE_VALID, 0);
        chk("rst_awaddr", bus.M_AXI_AWADDR, 0);
        chk("rst_awlen", bus.M_AXI_AWLEN, 0);
        chk("rst_awid", bus.M_AXI_AWID, 0);
        chk("rst_awburst", bus.M_AXI_AWBURST, 2'b01);
        chk("rst_awsize", bus.M_AXI_AWSIZE, 3'b010);
        chk("rst_bready", bus.M_AXI_BREADY, 1);
    endtask

    task automatic drive();
        logic [1:0]  v, wv;
        logic [63:0] a, d;
        logic [15:0] l;
        bent_t       e;
        for (int i = 0; i < 2; i++) begin
            if (rdy_seen[i]) begin
                streaming[i] = 1;
                sbeat[i] = 0;
                if (i == 0) cur[0] = rq0.pop_front();
                else        cur[1] = rq1.pop_front();
            end else if (whs_seen[i] && streaming[i]) begin
                sbeat[i]++;
                if (sbeat[i] > int'(cur[i].len)) streaming[i] = 0;
            end
        end
        v = 2'b00;
        a = {$urandom, $urandom};
        l = 16'($urandom);
        if (!streaming[0] && rq0.size() > 0) begin
            v[0] = 1'b1;
            a[31:0] = rq0[0].addr;
            l[7:0] = rq0[0].len;
        end
        if (!streaming[1] && rq1.size() > 0) begin
            v[1] = 1'b1;
            a[63:32] = rq1[0].addr;
            l[15:8] = rq1[0].len;
        end
        for (int i = 0; i < 2; i++) begin
            wv[i] = streaming[i] && ($urandom_range(99) < 32'(wv_pct));
            d[32*i +: 32] = streaming[i] ? bdata(cur[i], sbeat[i]) : $urandom;
        end
        bus.REQ_VALID  = v;
        bus.REQ_ADDR   = a;
        bus.REQ_LEN    = l;
        bus.REQ_WVALID = wv;
        bus.REQ_WDATA  = d;

        bus.M_AXI_BVALID = 1'b0;
        if (b_sync) begin
            // B only alongside an AW handshake
            bus.M_AXI_AWREADY = bus.M_AXI_AWVALID;
            if (bus.M_AXI_AWVALID && bq.size() > 0) begin
                e = bq.pop_front();
                bus.M_AXI_BID = e.id;
                bus.M_AXI_BRESP = e.resp;
                bus.M_AXI_BVALID = 1'b1;
            end
        end else begin
            if (awr_hold > 0 && bus.M_AXI_AWVALID) begin
                bus.M_AXI_AWREADY = 1'b0;
                awr_hold--;
            end else begin
                bus.M_AXI_AWREADY = awr_rand ? 1'($urandom_range(1)) : 1'b1;
            end
            if (bq.size() > 0 && bq[0].due <= 32'(cycno)) begin
                e = bq.pop_front();
                bus.M_AXI_BID = e.id;
                bus.M_AXI_BRESP = e.resp;
                bus.M_AXI_BVALID = 1'b1;
            end
        end
        wr_tog = ~wr_tog;
        case (wr_mode)
            0:       bus.M_AXI_WREADY = 1'b1;
            1:       bus.M_AXI_WREADY = wr_tog;
            default: bus.M_AXI_WREADY = 1'($urandom_range(1));
        endcase
    endtask

    task automatic cyc();
        logic [1:0] er, vld, en, rn, ew;
        logic [1:0] rs;
        bent_t      e;
        bit         wopen;
        int         g;
        @(negedge clk);
        if (rst_n) begin
            vld = bus.REQ_VALID;
            rdy_seen = bus.REQ_READY;
            whs_seen = bus.REQ_WVALID & bus.REQ_WREADY;
            er = 2'b00;
            g = 0;
            if (!burst_open && edges >= 1 && outstanding < MAXO
                && vld != 2'b00) begin
                if (vld == 2'b11) g = (last_g == 1) ? 0 : 1;
                else              g = vld[1] ? 1 : 0;
                er = (g == 1) ? 2'b10 : 2'b01;
            end
            chk("req_ready", bus.REQ_READY, er);
            chk("bready", bus.M_AXI_BREADY, 1);
            chk("awvalid", bus.M_AXI_AWVALID, burst_open && !aw_seen);
            if (bus.M_AXI_AWVALID && burst_open) begin
                chk("awaddr", bus.M_AXI_AWADDR, bo.addr);
                chk("awlen", bus.M_AXI_AWLEN, bo.len);
                chk("awid", bus.M_AXI_AWID, bo_req);
                chk("awsize", bus.M_AXI_AWSIZE, 3'b010);
                chk("awburst", bus.M_AXI_AWBURST, 2'b01);
            end
            wopen = burst_open && (wcnt <= int'(bo.len));
            chk("wvalid", bus.M_AXI_WVALID,
                wopen && bus.REQ_WVALID[bo_req]);
            ew = 2'b00;
            if (wopen && bus.M_AXI_WREADY) ew = (bo_req == 1) ? 2'b10 : 2'b01;
            chk("req_wready", bus.REQ_WREADY, ew);
            chk("done_valid", bus.DONE_VALID, exp_done);
            if (exp_done != 2'b00) begin
                rs = exp_done[1] ? bus.DONE_RESP[3:2] : bus.DONE_RESP[1:0];
                chk("done_resp", rs, exp_resp);
            end

            if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin
                aw_seen = 1;
                outstanding++;
                e.id = bus.M_AXI_AWID;
                case (resp_mode)
                    0:       e.resp = 2'b00;
                    1:       e.resp = 2'($urandom_range(3));
                    default: e.resp = 2'b10;
                endcase
                e.due = 32'(cycno) + (b_rand ? $urandom_range(10)
                                             : 32'(b_delay));
                bq.push_back(e);
            end
            if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
                chk("w_in_burst", wopen, 1);
                if (wopen) begin
                    chk("wdata", bus.M_AXI_WDATA, bdata(bo, wcnt));
                    chk("wlast", bus.M_AXI_WLAST, wcnt == int'(bo.len));
                    chk("wstrb", bus.M_AXI_WSTRB, 4'hF);
                end
                wcnt++;
            end
            en = 2'b00;
            rn = 2'b00;
            if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) begin
                outstanding--;
                en = bus.M_AXI_BID[0] ? 2'b10 : 2'b01;
                rn = bus.M_AXI_BRESP;
            end
            exp_done = en;
            exp_resp = rn;
            if (burst_open && aw_seen && wcnt == int'(bo.len) + 1)
                burst_open = 0;
            if (er != 2'b00) begin
                burst_open = 1;
                bo_req = g;
                bo = (g == 1) ? rq1[0] : rq0[0];
                aw_seen = 0;
                wcnt = 0;
                last_g = g;
            end
        end
        @(posedge clk);
        cycno++;
        if (rst_n) edges++;
        #1;
        drive();
    endtask

    task automatic run_idle(int lim, string tag);
        int n = 0;
        while (!idle() && n < lim) begin
            cyc();
            n++;
        end
        chk(tag, idle(), 1);
        repeat (3) cyc();
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        edges = 0;
        drive();
    endtask

    initial begin
        int n;
        total = 0;
        bad = 0;
        cycno = 0;
        edges = 0;
        bo = '0;
        bo_req = 0;
        rst_n = 1'b0;
        reset_model();
        zero_inputs();
        bus.REQ_VALID = 2'b11;
        bus.REQ_WVALID = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_rst();

        // single burst from requester 0
        rq0.push_back(mkb(32'h100, 8'd3));
        release_rst();
        run_idle(200, "single_timeout");

        // contention with outstanding cap
        b_delay = 8;
        for (int i = 0; i < 4; i++) begin
            rq0.push_back(mkb($urandom & 32'hFFFF_FFFC, 8'd0));
            rq1.push_back(mkb($urandom & 32'hFFFF_FFFC, 8'd0));
        end
        run_idle(400, "contention_timeout");

        // AW and W backpressure
        b_delay = 2;
        awr_hold = 5;
        wr_mode = 1;
        rq1.push_back(mkb($urandom & 32'hFFFF_FFFC, 8'd5));
        run_idle(200, "backpressure_timeout");

        // all W beats before the AW handshake
        wr_mode = 0;
        awr_hold = 12;
        rq0.push_back(mkb($urandom & 32'hFFFF_FFFC, 8'd3));
        rq1.push_back(mkb($urandom & 32'hFFFF_FFFC, 8'd0));
        run_idle(200, "w_before_aw_timeout");

        // B handshake coinciding with AW handshake
        b_sync = 1;
        resp_mode = 2;
        rq1.push_back(mkb($urandom & 32'hFFFF_FFFC, 8'd0));
        repeat (6) cyc();
        rq0.push_back(mkb($urandom & 32'hFFFF_FFFC, 8'd0));
        rq1.push_back(mkb($urandom & 32'hFFFF_FFFC, 8'd0));
        n = 0;
        while ((rq0.size() > 0 || rq1.size() > 0 || burst_open) && n < 100) begin
            cyc();
            n++;
        end
        chk("bsync_timeout", n < 100, 1);
        b_sync = 0;
        run_idle(100, "bsync_drain_timeout");

        // randomized traffic
        awr_rand = 1;
        wr_mode = 2;
        wv_pct = 60;
        b_rand = 1;
        resp_mode = 1;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(1) == 1)
                rq1.push_back(mkb($urandom, 8'($urandom_range(7))));
            else
                rq0.push_back(mkb($urandom, 8'($urandom_range(7))));
        end
        run_idle(5000, "random_timeout");

        // reset in the middle of a burst
        awr_rand = 0;
        wr_mode = 0;
        wv_pct = 100;
        b_rand = 0;
        resp_mode = 0;
        awr_hold = 20;
        rq0.push_back(mkb(32'h2000, 8'd3));
        n = 0;
        while (wcnt < 1 && n < 50) begin
            cyc();
            n++;
        end
        chk("midburst_timeout", wcnt >= 1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_rst();
        reset_model();
        zero_inputs();
        rq0.push_back(mkb(32'h3000, 8'd1));
        repeat (2) @(posedge clk);
        release_rst();
        run_idle(200, "post_reset_timeout");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
